booth_mul_seq: RTL and testbench

- Multi-cycle radix-4 (bit-pair recoded) Booth multiplier for the ALU MUL path.
- Retires one recoded digit per clock.
- Parametrised operand width and selectable signed/unsigned mode.
- start/busy/done handshake; registered HI/LO product feeds the HI and LO registers directly.

---
 rtl/booth_mul_seq.sv | 120 ++++++++++++
 tb/tb_booth_mul_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, WIDTH/2+1 RUN cycles,
// signed or unsigned operands, registered HI/LO product with a start/busy/done handshake.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int SW   = WIDTH + 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] m_sh;
  logic [SW-1:0]        sr;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] m_ext;
  logic [SW-1:0]        q_ext;
  logic                 accept;
  logic                 unused_acc_hi;

  // Map a Booth triplet onto the selected multiple of the (already 4^i-weighted) multiplicand.
  function automatic logic signed [AW-1:0] booth_term(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
    logic signed [AW-1:0] m2;
    m2 = m <<< 1;
    case (trip)
      3'b001, 3'b010: return m;
      3'b011:         return m2;
      3'b100:         return -m2;
      3'b101, 3'b110: return -m;
      default:        return '0;
    endcase
  endfunction

  assign accept   = start && (state != RUN);
  assign m_ext    = {{(AW-WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext    = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
  assign acc_next = acc + booth_term(sr[2:0], m_sh);

  // Guard bits above the 2*WIDTH product are only headroom for intermediate sums.
  assign unused_acc_hi = ^acc_next[AW-1:2*WIDTH];

  // Datapath: operand load on accept, one digit retired per RUN cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      acc  <= '0;
      m_sh <= m_ext;
      sr   <= q_ext;
    end else if (state == RUN) begin
      acc  <= acc_next;
      m_sh <= m_sh <<< 2;
      sr   <= sr >> 2;
    end
  end

  // Control FSM with registered busy/done and product capture on completion.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        RUN: begin
          if (count == CW'(NDIG - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            product_hi <= acc_next[2*WIDTH-1:WIDTH];
            product_lo <= acc_next[WIDTH-1:0];
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (WIDTH=32): hand-computed products, handshake timing,
// ignored start, back-to-back start, asynchronous clear, plus a model-checked random sweep.
module tb_booth_mul_seq;

  localparam int W    = 32;
  localparam int NDIG = W / 2 + 1;

  logic         clock = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int n_checks = 0;
  int n_err    = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    @(negedge clock);
    multiplicand = m;
    multiplier   = q;
    is_signed    = s;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Count cycles from the first negedge after acceptance until done; optionally poke
  // start with different operands at RUN cycle poke_at.
  task automatic wait_done(input int poke_at, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 200) begin
      if (busy) busy_n++;
      if (lat == poke_at) begin
        start        = 1'b1;
        multiplicand = 32'hFFFF_FFFF;
        multiplier   = 32'h1234_5678;
        is_signed    = ~is_signed;
      end
      @(negedge clock);
      start = 1'b0;
      lat++;
    end
    if (lat >= 200) check("done_timeout", 64'(lat), 64'(NDIG));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic s, input logic [63:0] exp);
    int lat, bn;
    launch(m, q, s);
    wait_done(-1, lat, bn);
    check({tag, "_prod"}, {product_hi, product_lo}, exp);
    check({tag, "_lat"}, 64'(lat), 64'(NDIG));
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                        input logic s);
    longint sp;
    logic [63:0] up;
    if (s) begin
      sp = longint'($signed(m)) * longint'($signed(q));
      return 64'(sp);
    end
    up = {32'h0, m} * {32'h0, q};
    return up;
  endfunction

  initial begin
    int lat, bn, dcount;
    logic [W-1:0] rm, rq;
    logic rs;

    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {product_hi, product_lo}, 64'd0);
    clear = 1'b0;

    // -7 x 3 signed: latency, busy width and done pulse width
    launch(32'hFFFF_FFF9, 32'h3, 1'b1);
    wait_done(-1, lat, bn);
    check("neg7x3_prod", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("neg7x3_lat", 64'(lat), 64'd17);
    check("neg7x3_busy_cycles", 64'(bn), 64'd17);
    check("neg7x3_busy_at_done", 64'(busy), 64'd0);
    @(negedge clock);
    check("neg7x3_done_pulse", 64'(done), 64'd0);
    check("neg7x3_hold", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("s_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);
    run_op("u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_8000_0000);
    run_op("s_zero", 32'h0, 32'h8000_0001, 1'b1, 64'h0);

    // start and operand changes during RUN are ignored
    launch(32'd5, 32'd6, 1'b1);
    wait_done(5, lat, bn);
    check("ignore_prod", {product_hi, product_lo}, 64'd30);
    check("ignore_lat", 64'(lat), 64'd17);

    // start held in DONE: new op starts at once, old product held while it runs
    multiplicand = 32'd1000;
    multiplier   = 32'hFFFF_FFFE;
    is_signed    = 1'b1;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_hold", {product_hi, product_lo}, 64'd30);
    wait_done(-1, lat, bn);
    check("b2b_prod", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_F830);
    check("b2b_lat", 64'(lat), 64'd17);

    // asynchronous clear mid-run
    launch(32'd12345, 32'd678, 1'b1);
    repeat (7) @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_prod", {product_hi, product_lo}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done || busy) dcount++;
    end
    check("clr_no_done", 64'(dcount), 64'd0);
    run_op("post_clr_12x12", 32'd12, 32'd12, 1'b0, 64'd144);

    // clear in the same cycle as start wins
    @(negedge clock);
    multiplicand = 32'd3;
    multiplier   = 32'd3;
    start        = 1'b1;
    clear        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear = 1'b0;
    check("clr_vs_start_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 200; i++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op("rand", rm, rq, rs, model(rm, rq, rs));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
